// File: rtl/button_debounce_bank_if.sv
// Button bank signal bundle: raw pads in, conditioned level/pulse outputs back.
// No valid/ready: btn_level/btn_long are levels; press/release/repeat are single-cycle strobes.
interface button_debounce_bank_if #(
  parameter int NCH = 5
);
  logic [NCH-1:0] btn_in;
  logic [NCH-1:0] btn_level;
  logic [NCH-1:0] btn_press;
  logic [NCH-1:0] btn_release;
  logic [NCH-1:0] btn_long;
  logic [NCH-1:0] btn_repeat;

  modport master (
    output btn_in,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_long,
    input  btn_repeat
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_long,
    output btn_repeat
  );
endinterface

// File: rtl/button_debounce_bank.sv
// Multi-channel push-button conditioner: sync, tick-based debounce, press/release
// strobes, long-press flag and auto-repeat, all channels sharing one tick divider.
module button_debounce_bank #(
  parameter int NCH          = 5,
  parameter int CLK_DIV      = 100000,
  parameter int DB_TICKS     = 20,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic                 clk,
  input  logic                 reset_n,
  button_debounce_bank_if.slave bus
);

  localparam int TW = $clog2(CLK_DIV);
  localparam int CW = $clog2(DB_TICKS + 1);
  localparam int HW = $clog2(LONG_TICKS + 1);
  localparam int RW = $clog2(REPEAT_TICKS + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DB_TICKS - 1);
  localparam logic [HW-1:0] H_LAST    = HW'(LONG_TICKS - 1);
  localparam logic [HW-1:0] H_MAX     = HW'(LONG_TICKS);
  localparam logic [RW-1:0] R_LAST    = RW'(REPEAT_TICKS - 1);

  logic [TW-1:0] div_cnt;
  logic          tick;

  assign tick = (div_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic          s1;
    logic          s2;
    logic          lvl;
    logic          prs;
    logic          rls;
    logic          lng;
    logic          rpt;
    logic [CW-1:0] c;
    logic [HW-1:0] h;
    logic [RW-1:0] r;
    logic          accept;

    // accept marks the edge on which the synchronised input becomes the new level
    assign accept = (s2 != lvl) && tick && (c == DB_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        s1  <= 1'b0;
        s2  <= 1'b0;
        lvl <= 1'b0;
        prs <= 1'b0;
        rls <= 1'b0;
        lng <= 1'b0;
        rpt <= 1'b0;
        c   <= '0;
        h   <= '0;
        r   <= '0;
      end else begin
        s1  <= bus.btn_in[g];
        s2  <= s1;
        prs <= accept && s2;
        rls <= accept && !s2;
        rpt <= 1'b0;

        if (s2 == lvl) begin
          c <= '0;
        end else if (tick) begin
          if (c == DB_LAST) begin
            lvl <= s2;
            c   <= '0;
          end else begin
            c <= c + 1'b1;
          end
        end

        // A release accepted on a tick edge takes priority over any hold/repeat event.
        if (!lvl || (accept && !s2)) begin
          h   <= '0;
          r   <= '0;
          lng <= 1'b0;
        end else if (tick) begin
          if (h != H_MAX) begin
            h <= h + 1'b1;
          end
          if (h == H_LAST) begin
            lng <= 1'b1;
            rpt <= 1'b1;
            r   <= '0;
          end else if (lng) begin
            if (r == R_LAST) begin
              rpt <= 1'b1;
              r   <= '0;
            end else begin
              r <= r + 1'b1;
            end
          end
        end
      end
    end

    assign bus.btn_level[g]   = lvl;
    assign bus.btn_press[g]   = prs;
    assign bus.btn_release[g] = rls;
    assign bus.btn_long[g]    = lng;
    assign bus.btn_repeat[g]  = rpt;
  end

endmodule

// File: doc/button_debounce_bank.md
# button_debounce_bank

Parametrised multi-channel push-button conditioner for the board's front-panel inputs. Each channel synchronises a raw pad input and debounces it against a shared millisecond-scale tick. It produces a stable level, one-cycle press/release pulses, a long-press flag and auto-repeat pulses. It sits between the FPGA button pins and the processor's control/step logic, replacing per-button single-channel debouncers.

## Interface
- NCH, 5, number of independent button channels (≥1)
- CLK_DIV, 100000, clk cycles per debounce tick (≥2; 1 ms at 100 MHz)
- DB_TICKS, 20, consecutive ticks of disagreement required to accept a new level (≥1)
- LONG_TICKS, 1000, ticks of accepted-high level before long-press asserts (≥1)
- REPEAT_TICKS, 200, ticks between auto-repeat pulses once long-press is active (≥1)

- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- btn_in  in  NCH  raw, asynchronous button pads, active-high
- btn_level  out  NCH  debounced level
- btn_press  out  NCH  one-cycle pulse on accepted 0→1
- btn_release  out  NCH  one-cycle pulse on accepted 1→0
- btn_long  out  NCH  high while held ≥ LONG_TICKS ticks
- btn_repeat  out  NCH  one-cycle auto-repeat pulses while btn_long is high

## Operation
- Reset (reset_n low, asynchronous): every flop and every output is 0; no pulses are generated on reset release.
- Synchroniser: 2-flop chain per channel, reset to 0; its output is `s`.
- Tick generator (shared): counter 0..CLK_DIV-1 wraps; `tick` is high for one cycle when counter == CLK_DIV-1. Width is $clog2(CLK_DIV).
- Debounce, per channel: accepted level `L` and disagreement counter `c` (width $clog2(DB_TICKS+1)).
  - Any cycle with s == L: c ← 0.
  - s ≠ L and tick: if c == DB_TICKS-1, then L ← s and c ← 0; else c ← c+1.
  - Bounce does not force btn_level low; btn_level holds its last accepted value.
- Pulses: btn_press/btn_release are registered and high for exactly the one cycle in which btn_level first shows the new value.
- Hold counter `h` (saturating at LONG_TICKS): cleared while L=0; increments on tick while L=1.
  - btn_long rises on the edge where h reaches LONG_TICKS.
  - btn_long stays high until L falls.
- Repeat counter `r`: cleared while btn_long=0.
  - btn_repeat pulses in the same cycle btn_long rises.
  - After that, btn_repeat pulses once every REPEAT_TICKS ticks while btn_long stays high.
- Simultaneous events: a level acceptance to 0 on the same edge as a tick clears h, r and btn_long, with no long/repeat pulse. Release wins.
- Channels are fully independent apart from the shared tick. Any combination of channels may pulse in the same cycle.

## Timing
- btn_in edge → s: 2 clk.
- s change → btn_level: on the DB_TICKS-th tick with s ≠ L held continuously. The total is between (DB_TICKS-1)·CLK_DIV+3 and DB_TICKS·CLK_DIV+3 cycles after a clean btn_in edge, depending on tick phase.
- btn_press/btn_release are coincident with the btn_level change (same cycle), with 1-cycle width.
- btn_long is high from the LONG_TICKS-th tick after btn_level rose, visible the cycle after that tick.
- btn_repeat period is REPEAT_TICKS·CLK_DIV cycles exactly.
- btn_level, btn_long and btn_repeat all drop on the same edge as a release acceptance.
- Button held through reset release: L rises after debounce and btn_press pulses once. This is intentional.

## Test plan
Bench parameters: NCH=3, CLK_DIV=4, DB_TICKS=3, LONG_TICKS=10, REPEAT_TICKS=4.
- Reset/idle: reset_n=0 then 1, btn_in=000 for 100 cycles → all outputs 0, no pulses.
- Clean press ch0: btn_in[0] 0→1 held → btn_level[0]=1 within 11–15 cycles, btn_press[0] high exactly 1 cycle in the same cycle, ch1/ch2 stay 0.
- Bounce rejection: btn_in[1] toggles every 5 cycles for 60 cycles, then held 1 → no pulse during toggling; a single btn_press[1] follows 11–15 cycles after it settles.
- Long press and repeat: ch0 held 200 cycles.
  - btn_long[0] and the first btn_repeat[0] appear 40 cycles after btn_press[0].
  - Further repeats follow every 16 cycles.
  - Release → btn_release[0] pulse, and btn_level/btn_long drop together on that edge.
- Async reset mid-hold: reset_n low for 3 cycles while ch2 is long-pressed → all outputs 0 immediately, without waiting for clk. After reset release with the button still held, one btn_press[2] occurs and btn_long[2] re-asserts after 40 further cycles.
- Concurrency: ch0 releases and ch1 presses with identical btn_in timing → btn_release[0] and btn_press[1] occur in the same cycle.
